// File: rtl/uart_tx_arbiter.sv
// Two-requester round-robin arbiter feeding a single 8N1 UART transmitter.
// Grants are frame-atomic and a requester keeps the line until it sends a byte flagged last.
module uart_tx_arbiter #(
  parameter int BAUD_DIV     = 434,
  parameter int STOP_BITS    = 1,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic [7:0] req0_data_i,
  input  logic       req0_valid_i,
  input  logic       req0_last_i,
  output logic       req0_ready_o,
  input  logic [7:0] req1_data_i,
  input  logic       req1_valid_i,
  input  logic       req1_last_i,
  output logic       req1_ready_o,
  output logic       txd_o,
  output logic [1:0] grant_o,
  output logic       busy_o
);

  localparam int STOP_LEN = STOP_BITS * BAUD_DIV;
  localparam int CNT_W    = (STOP_LEN > 1) ? $clog2(STOP_LEN) : 1;
  localparam int TO_W     = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;

  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] STOP_END = CNT_W'(STOP_LEN - 1);
  localparam logic [TO_W-1:0]  HOLD_END = TO_W'((LOCK_TIMEOUT > 0) ? LOCK_TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, HOLD} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [2:0]       idx, idx_nx;
  logic [TO_W-1:0]  hold_cnt, hold_cnt_nx;
  logic             owner, owner_nx;
  logic             ptr, ptr_nx;
  logic             last, last_nx;
  logic             txd, txd_nx;
  logic [1:0]       grant, grant_nx;
  logic [7:0]       shift;
  logic             take0, take1;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state    <= IDLE;
      cnt      <= '0;
      idx      <= '0;
      hold_cnt <= '0;
      owner    <= 1'b0;
      ptr      <= 1'b0;
      last     <= 1'b0;
      grant    <= 2'b00;
      txd      <= 1'b1;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      idx      <= idx_nx;
      hold_cnt <= hold_cnt_nx;
      owner    <= owner_nx;
      ptr      <= ptr_nx;
      last     <= last_nx;
      grant    <= grant_nx;
      txd      <= txd_nx;
    end
  end

  // Payload byte only; it is always written before it is first shifted out.
  always_ff @(posedge clk_i) begin
    if (take0 || take1) shift <= take1 ? req1_data_i : req0_data_i;
  end

  always_comb begin
    state_nx    = state;
    cnt_nx      = '0;
    idx_nx      = idx;
    hold_cnt_nx = '0;
    owner_nx    = owner;
    ptr_nx      = ptr;
    last_nx     = last;
    grant_nx    = grant;
    take0       = 1'b0;
    take1       = 1'b0;
    case (state)
      IDLE: begin
        if (req0_valid_i && (!req1_valid_i || !ptr)) take0 = 1'b1;
        else if (req1_valid_i)                        take1 = 1'b1;
      end
      START: begin
        cnt_nx = cnt + CNT_W'(1);
        if (cnt == BIT_END) begin
          cnt_nx   = '0;
          idx_nx   = 3'd0;
          state_nx = DATA;
        end
      end
      DATA: begin
        cnt_nx = cnt + CNT_W'(1);
        if (cnt == BIT_END) begin
          cnt_nx = '0;
          idx_nx = idx + 3'd1;
          if (idx == 3'd7) state_nx = STOP;
        end
      end
      STOP: begin
        cnt_nx = cnt + CNT_W'(1);
        if (cnt == STOP_END) begin
          cnt_nx = '0;
          if (last) begin
            state_nx = IDLE;
            grant_nx = 2'b00;
            ptr_nx   = ~owner;
          end else begin
            state_nx = HOLD;
          end
        end
      end
      HOLD: begin
        hold_cnt_nx = (LOCK_TIMEOUT == 0) ? hold_cnt : hold_cnt + TO_W'(1);
        if (owner ? req1_valid_i : req0_valid_i) begin
          take0 = ~owner;
          take1 = owner;
        end else if (LOCK_TIMEOUT != 0 && hold_cnt == HOLD_END) begin
          state_nx = IDLE;
          grant_nx = 2'b00;
          ptr_nx   = ~owner;
        end
      end
      default: state_nx = IDLE;
    endcase

    if (take0 || take1) begin
      state_nx = START;
      cnt_nx   = '0;
      owner_nx = take1;
      last_nx  = take1 ? req1_last_i : req0_last_i;
      grant_nx = take1 ? 2'b10 : 2'b01;
    end

    // The line level is registered from the state being entered, so txd_o never glitches.
    case (state_nx)
      START:   txd_nx = 1'b0;
      DATA:    txd_nx = shift[idx_nx];
      default: txd_nx = 1'b1;
    endcase
  end

  assign req0_ready_o = take0 & rstn_i;
  assign req1_ready_o = take1 & rstn_i;
  assign txd_o        = txd;
  assign grant_o      = grant;
  assign busy_o       = (state != IDLE);

endmodule
